// File: rtl/updown_counter_bank.sv
// updown_counter_bank: NCH independent WID-bit up/down counters with
// per-channel clear/load, saturate or wrap at the range ends, full/empty
// decodes and sticky overflow/underflow flags.
// Optional feature: define UDC_BANK_THRESH_EN to add the per-channel
// threshold compare (thr_i / thr_o). Without it no comparator is built.
module updown_counter_bank #(
  parameter int WID      = 4,
  parameter int NCH      = 2,
  parameter int SATURATE = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NCH-1:0]     up_i,
  input  logic [NCH-1:0]     down_i,
  input  logic [NCH-1:0]     clr_i,
  input  logic [NCH-1:0]     load_i,
  input  logic [NCH*WID-1:0] load_val_i,
  input  logic               flag_clr_i,
`ifdef UDC_BANK_THRESH_EN
  input  logic [NCH*WID-1:0] thr_i,
  output logic [NCH-1:0]     thr_o,
`endif
  output logic [NCH*WID-1:0] cnt_o,
  output logic [NCH-1:0]     full_o,
  output logic [NCH-1:0]     empty_o,
  output logic [NCH-1:0]     ovf_o,
  output logic [NCH-1:0]     unf_o
);

  localparam logic [WID-1:0] CNT_MAX = '1;
  localparam logic [WID-1:0] CNT_MIN = '0;

  // Increment with end-of-range handling: clamp at max or wrap to zero.
  function automatic logic [WID-1:0] sat_inc(input logic [WID-1:0] c);
    if (c == CNT_MAX)
      return (SATURATE != 0) ? CNT_MAX : CNT_MIN;
    return c + 1'b1;
  endfunction

  // Decrement with end-of-range handling: clamp at zero or wrap to max.
  function automatic logic [WID-1:0] sat_dec(input logic [WID-1:0] c);
    if (c == CNT_MIN)
      return (SATURATE != 0) ? CNT_MIN : CNT_MAX;
    return c - 1'b1;
  endfunction

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [WID-1:0] cnt_p0;
    logic           ovf_p0;
    logic           unf_p0;
    logic           inc_only;
    logic           dec_only;
    logic           ovf_set;
    logic           unf_set;

    // Net direction request; up and down together cancel out, load masks both.
    assign inc_only = up_i[ch] & ~down_i[ch] & ~load_i[ch];
    assign dec_only = down_i[ch] & ~up_i[ch] & ~load_i[ch];
    assign ovf_set  = inc_only & (cnt_p0 == CNT_MAX);
    assign unf_set  = dec_only & (cnt_p0 == CNT_MIN);

    // Count and sticky flags: reset > clear > load > up/down; a flag set
    // event beats the bank-wide flag clear in the same cycle.
    always_ff @(posedge clk_i) begin
      if (rst_i || clr_i[ch]) begin
        cnt_p0 <= '0;
        ovf_p0 <= 1'b0;
        unf_p0 <= 1'b0;
      end else begin
        if (load_i[ch])
          cnt_p0 <= load_val_i[ch*WID +: WID];
        else if (inc_only)
          cnt_p0 <= sat_inc(cnt_p0);
        else if (dec_only)
          cnt_p0 <= sat_dec(cnt_p0);

        if (ovf_set)
          ovf_p0 <= 1'b1;
        else if (flag_clr_i)
          ovf_p0 <= 1'b0;

        if (unf_set)
          unf_p0 <= 1'b1;
        else if (flag_clr_i)
          unf_p0 <= 1'b0;
      end
    end

    assign cnt_o[ch*WID +: WID] = cnt_p0;
    assign full_o[ch]           = (cnt_p0 == CNT_MAX);
    assign empty_o[ch]          = (cnt_p0 == CNT_MIN);
    assign ovf_o[ch]            = ovf_p0;
    assign unf_o[ch]            = unf_p0;

`ifdef UDC_BANK_THRESH_EN
    assign thr_o[ch] = (cnt_p0 >= thr_i[ch*WID +: WID]);
`endif
  end

endmodule
